// File: rtl/rv32i_types.sv
// Shared rv32i pipeline types.
// Holds the hazard controller state encoding and the bundle of stage
// controls that the controller decodes every cycle.
package rv32i_types;

  // Hazard controller states: normal issue, or waiting for a decoded branch to resolve in exec
  typedef enum logic {
    RUN     = 1'b0,
    BR_WAIT = 1'b1
  } ctrl_state_t;

  // Per-cycle pipeline controls driven by the hazard controller
  typedef struct packed {
    logic load_pc;
    logic load_decode;
    logic load_exec;
    logic load_mem;
    logic load_wb;
    logic bubble_decode;
    logic bubble_exec;
    logic pc_sel;
  } hz_ctrl_t;

  localparam int unsigned HZ_CNT_W_DEFAULT = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, reset_n (async active-low), clr (sync clear, wins over inc),
//        inc (count one event), count (current value, sticks at all-ones).
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Increment unless already at the all-ones ceiling
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller for the 5-stage rv32i pipeline.
// Resolves load-use, branch-in-decode and memory-wait hazards by driving
// stage load enables, bubble inserts and PC select (combinational, zero
// latency from the inputs), and keeps saturating event counters.
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   ex_load_use, dec_branch           hazard flags from exec/decode
//   ex_br_resolved, ex_br_taken       branch outcome from exec
//   imem_read/imem_resp, dmem_req/dmem_resp  memory handshakes
//   load_pc..load_wb                  stage register load enables
//   bubble_decode, bubble_exec        insert NOP into that stage register
//   pc_sel                            0 = pc+4, 1 = branch target
//   cnt_clr                           sync clear of all counters
//   cnt_mem_stall, cnt_lu_stall, cnt_br_bubble  saturating counters
module hazard_ctrl
  import rv32i_types::*;
#(
  parameter int unsigned CNT_W = HZ_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ex_load_use,
  input  logic             dec_branch,
  input  logic             ex_br_resolved,
  input  logic             ex_br_taken,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  output logic             load_pc,
  output logic             load_decode,
  output logic             load_exec,
  output logic             load_mem,
  output logic             load_wb,
  output logic             bubble_decode,
  output logic             bubble_exec,
  output logic             pc_sel,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_mem_stall,
  output logic [CNT_W-1:0] cnt_lu_stall,
  output logic [CNT_W-1:0] cnt_br_bubble
);

  ctrl_state_t state, state_nxt;
  hz_ctrl_t    ctl;
  logic        mem_wait;
  logic        ev_mem, ev_lu, ev_br;

  assign mem_wait = (imem_read & ~imem_resp) | (dmem_req & ~dmem_resp);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, stage controls and counter events; mem_wait > load-use > branch
  always_comb begin
    state_nxt = state;
    ctl       = '0;
    ev_mem    = 1'b0;
    ev_lu     = 1'b0;
    ev_br     = 1'b0;
    if (!reset_n) begin
      state_nxt = RUN;
    end else if (mem_wait) begin
      // Full freeze; a pending resolve is deferred until memory answers
      ev_mem = 1'b1;
    end else if (state == RUN) begin
      if (ex_load_use) begin
        // Hold fetch/decode, push a NOP into exec, let mem/wb drain
        ctl.load_exec   = 1'b1;
        ctl.bubble_exec = 1'b1;
        ctl.load_mem    = 1'b1;
        ctl.load_wb     = 1'b1;
        ev_lu           = 1'b1;
      end else if (dec_branch) begin
        // Branch moves on to exec; fetch holds the fall-through instruction
        ctl.load_decode   = 1'b1;
        ctl.load_exec     = 1'b1;
        ctl.load_mem      = 1'b1;
        ctl.load_wb       = 1'b1;
        ctl.bubble_decode = 1'b1;
        ev_br             = 1'b1;
        state_nxt         = BR_WAIT;
      end else begin
        ctl.load_pc     = 1'b1;
        ctl.load_decode = 1'b1;
        ctl.load_exec   = 1'b1;
        ctl.load_mem    = 1'b1;
        ctl.load_wb     = 1'b1;
      end
    end else begin
      // BR_WAIT: decode keeps a bubble; load-use cannot apply here
      ctl.load_decode   = 1'b1;
      ctl.load_exec     = 1'b1;
      ctl.load_mem      = 1'b1;
      ctl.load_wb       = 1'b1;
      ctl.bubble_decode = 1'b1;
      ev_br             = 1'b1;
      if (ex_br_resolved) begin
        ctl.load_pc = 1'b1;
        ctl.pc_sel  = ex_br_taken;
        state_nxt   = RUN;
      end
    end
  end

  assign load_pc       = ctl.load_pc;
  assign load_decode   = ctl.load_decode;
  assign load_exec     = ctl.load_exec;
  assign load_mem      = ctl.load_mem;
  assign load_wb       = ctl.load_wb;
  assign bubble_decode = ctl.bubble_decode;
  assign bubble_exec   = ctl.bubble_exec;
  assign pc_sel        = ctl.pc_sel;

  // Performance counters
  sat_counter #(.W(CNT_W)) u_cnt_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (ev_mem),
    .count   (cnt_mem_stall)
  );

  sat_counter #(.W(CNT_W)) u_cnt_lu (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (ev_lu),
    .count   (cnt_lu_stall)
  );

  sat_counter #(.W(CNT_W)) u_cnt_br (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (ev_br),
    .count   (cnt_br_bubble)
  );

endmodule
